// File: rtl/tv_sequencer.sv
// Self-checking test-vector engine: replays {valid, inputs, expected} entries into a small
// combinational block, compares its response one cycle later and tallies vectors and mismatches.
module tv_sequencer #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [IN_W+OUT_W:0]   wr_data,
    input  logic                  start,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W:0]       vec_count,
    output logic [ADDR_W:0]       err_count,
    output logic                  err_pulse,
    output logic [ADDR_W-1:0]     err_index,
    output logic [OUT_W-1:0]      err_got
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam int                CNT_W    = ADDR_W + 1;
    localparam int                VALID_B  = IN_W + OUT_W;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Vector memory: valid bits are control state, data fields are plain storage.
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [IN_W-1:0]   in_mem_q  [DEPTH];
    logic [OUT_W-1:0]  exp_mem_q [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [IN_W-1:0]   dut_in_q, dut_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  vec_count_q, vec_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ADDR_W-1:0] err_index_q, err_index_d;
    logic [OUT_W-1:0]  err_got_q, err_got_d;

    logic              wr_accept;
    logic [ADDR_W-1:0] idx_inc;
    logic              is_last;
    logic              mismatch;
    logic [CNT_W-1:0]  err_sat_inc;

    assign wr_accept = wr_en && !busy_q;
    assign idx_inc   = idx_q + ADDR_W'(1);
    // The end-of-memory test comes first so idx_inc wrapping to 0 never selects a valid bit.
    assign is_last   = (idx_q == IDX_LAST) || !valid_q[idx_inc];
    assign mismatch  = (dut_out != exp_mem_q[idx_q]);
    assign err_sat_inc = (err_count_q == '1) ? err_count_q : err_count_q + CNT_ONE;

    always_comb begin
        // NOTE: every _d is given its hold value first, so no branch below can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        dut_in_d    = dut_in_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        err_index_d = err_index_q;
        err_got_d   = err_got_q;
        valid_d     = valid_q;

        if (wr_accept) begin
            valid_d[wr_addr] = wr_data[VALID_B];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d       = '0;
                    vec_count_d = '0;
                    err_count_d = '0;
                    if (valid_q[0]) begin
                        state_d = S_APPLY;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end else begin
                        // Empty memory: an immediately finished, trivially passing run.
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end
                end
            end
            S_APPLY: begin
                dut_in_d = in_mem_q[idx_q];
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                vec_count_d = vec_count_q + CNT_ONE;
                if (mismatch) begin
                    err_count_d = err_sat_inc;
                    err_pulse_d = 1'b1;
                    err_index_d = idx_q;
                    err_got_d   = dut_out;
                end
                if (is_last) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // Uses the updated count so a mismatch on the last vector fails the run.
                    pass_d  = (err_count_d == '0);
                end else begin
                    idx_d   = idx_inc;
                    state_d = S_APPLY;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            dut_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            vec_count_q <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            err_index_q <= '0;
            err_got_q   <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dut_in_q    <= dut_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            err_index_q <= err_index_d;
            err_got_q   <= err_got_d;
            valid_q     <= valid_d;
        end
    end

    // NOTE: the data array has no reset; cleared valid bits already make stale data unreachable.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            in_mem_q[wr_addr]  <= wr_data[OUT_W +: IN_W];
            exp_mem_q[wr_addr] <= wr_data[OUT_W-1:0];
        end
    end

    assign dut_in    = dut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign vec_count = vec_count_q;
    assign err_count = err_count_q;
    assign err_pulse = err_pulse_q;
    assign err_index = err_index_q;
    assign err_got   = err_got_q;

endmodule
